// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, OCW2 command codes and level helpers for the PIC control core
package pic_pkg;

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    CMD_READY
  } icw_state_t;

  typedef enum logic [1:0] {
    ACK_IDLE,
    ACK_1,
    ACK_2
  } ack_state_t;

  localparam logic [2:0] OCW2_CLR_AUTO_ROT = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_S_EOI        = 3'b011;
  localparam logic [2:0] OCW2_SET_AUTO_ROT = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

  // Works on the widest legal level vector; callers zero-extend and slice.
  function automatic logic [4:0] bit2num(input logic [31:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) n = 5'(i);
    end
    return n;
  endfunction

  function automatic logic [31:0] num2bit(input logic [4:0] n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/pic_ack_sequencer.sv
// rtl/pic_ack_sequencer.sv - INTA acknowledge sequencer: freeze, ISR latch strobe, acknowledged level
// o_ack_done is a same-cycle flag for the final INTA of a sequence.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_abort,
  input  logic             i_inta_pulse,
  input  logic             i_mode_8086,
  input  logic [N_IRQ-1:0] i_interrupt,
  output logic             o_freeze,
  output logic             o_latch_in_service,
  output logic [N_IRQ-1:0] o_acknowledge_interrupt,
  output logic             o_ack_done
);

  ack_state_t r_state;
  ack_state_t w_next_state;
  logic       w_start;

  always_comb begin
    w_next_state = r_state;
    o_ack_done   = 1'b0;
    if (i_abort) begin
      w_next_state = ACK_IDLE;
    end else if (i_inta_pulse) begin
      case (r_state)
        ACK_IDLE: w_next_state = ACK_1;
        ACK_1: begin
          if (i_mode_8086) begin
            w_next_state = ACK_IDLE;
            o_ack_done   = 1'b1;
          end else begin
            w_next_state = ACK_2;
          end
        end
        ACK_2: begin
          w_next_state = ACK_IDLE;
          o_ack_done   = 1'b1;
        end
        default: w_next_state = ACK_IDLE;
      endcase
    end
  end

  assign w_start = !i_abort && i_inta_pulse && (r_state == ACK_IDLE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state                 <= ACK_IDLE;
      o_freeze                <= 1'b0;
      o_latch_in_service      <= 1'b0;
      o_acknowledge_interrupt <= '0;
    end else begin
      r_state            <= w_next_state;
      o_freeze           <= (w_next_state != ACK_IDLE);
      o_latch_in_service <= w_start;
      if (w_start) o_acknowledge_interrupt <= i_interrupt;
    end
  end

endmodule

// File: rtl/pic_control_core.sv
// rtl/pic_control_core.sv - PIC control core: ICW sequencer, multi-byte IMR, rotation and EOI generation
// ICW1 overrides every other event in the cycle it is strobed.
module pic_control_core
  import pic_pkg::*;
#(
  parameter  int N_IRQ  = 8,
  localparam int IDW    = $clog2(N_IRQ),
  localparam int NBYTES = (N_IRQ + 7) / 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       internal_data_bus,
  input  logic             write_initial_command_word_1,
  input  logic             write_initial_command_word_2_4,
  input  logic             write_operation_control_word_1,
  input  logic             write_operation_control_word_2,
  input  logic             write_operation_control_word_3,
  input  logic             inta_pulse,
  input  logic [N_IRQ-1:0] interrupt,
  input  logic [N_IRQ-1:0] highest_level_in_service,
  output logic [N_IRQ-1:0] interrupt_mask,
  output logic [N_IRQ-1:0] interrupt_special_mask,
  output logic [N_IRQ-1:0] end_of_interrupt,
  output logic [IDW-1:0]   priority_rotate,
  output logic             freeze,
  output logic             latch_in_service,
  output logic [N_IRQ-1:0] clear_interrupt_request,
  output logic             mode_8086,
  output logic             init_done
);

  localparam int LPW = (IDW > 3) ? IDW - 3 : 1;
  localparam int PW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  icw_state_t       r_icw_state, w_icw_next;
  logic             r_sngl, r_ic4, r_aeoi, r_auto_rotate, r_smm;
  logic [LPW-1:0]   r_level_page;
  logic [PW-1:0]    r_byte_ptr;
  logic             w_ready, w_ocw1, w_ocw2, w_ocw3;
  logic [5:0]       w_level;
  logic             w_level_ok;
  logic [31:0]      w_level_onehot32, w_byte_sel32, w_ocw1_new32;
  logic [4:0]       w_hlis_num, w_ack_num;
  logic [N_IRQ-1:0] w_ocw2_eoi, w_aeoi_eoi, w_ack_int;
  logic             w_ocw2_rot, w_aeoi_rot, w_ack_done, w_unused;
  logic [IDW-1:0]   w_ocw2_rot_val;

  assign w_ready = (r_icw_state == CMD_READY);
  assign w_ocw1  = write_operation_control_word_1 && w_ready;
  assign w_ocw2  = write_operation_control_word_2 && w_ready;
  assign w_ocw3  = write_operation_control_word_3 && w_ready;

  assign w_level          = 6'({r_level_page, internal_data_bus[2:0]});
  assign w_level_ok       = (w_level < 6'(N_IRQ));
  assign w_level_onehot32 = num2bit(w_level[4:0]);
  assign w_hlis_num       = bit2num(32'(highest_level_in_service));
  assign w_ack_num        = bit2num(32'(w_ack_int));

  // Byte lane selected by the OCW1 pointer; bits past N_IRQ fall off on truncation.
  assign w_byte_sel32 = 32'hFF << {r_byte_ptr, 3'b000};
  assign w_ocw1_new32 = (32'(r_smm ? interrupt_special_mask : interrupt_mask) & ~w_byte_sel32)
                      | (32'(internal_data_bus) << {r_byte_ptr, 3'b000});
  assign w_unused     = ^{w_level_onehot32, w_hlis_num, w_ack_num, w_ocw1_new32};

  always_comb begin
    w_icw_next = r_icw_state;
    if (write_initial_command_word_1) begin
      w_icw_next = WAIT_ICW2;
    end else if (write_initial_command_word_2_4) begin
      case (r_icw_state)
        WAIT_ICW2: w_icw_next = !r_sngl ? WAIT_ICW3 : (r_ic4 ? WAIT_ICW4 : CMD_READY);
        WAIT_ICW3: w_icw_next = r_ic4 ? WAIT_ICW4 : CMD_READY;
        WAIT_ICW4: w_icw_next = CMD_READY;
        default:   w_icw_next = r_icw_state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_icw_state <= WAIT_ICW1;
    else       r_icw_state <= w_icw_next;
  end

  always_comb begin
    w_ocw2_eoi     = '0;
    w_ocw2_rot     = 1'b0;
    w_ocw2_rot_val = '0;
    if (w_ocw2) begin
      case (internal_data_bus[7:5])
        OCW2_NS_EOI: w_ocw2_eoi = highest_level_in_service;
        OCW2_ROT_NS_EOI: begin
          w_ocw2_eoi     = highest_level_in_service;
          w_ocw2_rot     = |highest_level_in_service;
          w_ocw2_rot_val = w_hlis_num[IDW-1:0];
        end
        OCW2_S_EOI: if (w_level_ok) w_ocw2_eoi = w_level_onehot32[N_IRQ-1:0];
        OCW2_ROT_S_EOI: if (w_level_ok) begin
          w_ocw2_eoi     = w_level_onehot32[N_IRQ-1:0];
          w_ocw2_rot     = 1'b1;
          w_ocw2_rot_val = w_level[IDW-1:0];
        end
        OCW2_SET_PRIO: if (w_level_ok) begin
          w_ocw2_rot     = 1'b1;
          w_ocw2_rot_val = w_level[IDW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign w_aeoi_eoi = (w_ack_done && r_aeoi) ? w_ack_int : '0;
  assign w_aeoi_rot = w_ack_done && r_aeoi && r_auto_rotate && (|w_ack_int);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      interrupt_mask         <= '1;
      interrupt_special_mask <= '0;
      end_of_interrupt       <= '0;
      priority_rotate        <= IDW'(N_IRQ - 1);
      mode_8086              <= 1'b0;
      r_aeoi                 <= 1'b0;
      r_auto_rotate          <= 1'b0;
      r_smm                  <= 1'b0;
      r_level_page           <= '0;
      r_byte_ptr             <= '0;
      r_sngl                 <= 1'b0;
      r_ic4                  <= 1'b0;
    end else if (write_initial_command_word_1) begin
      interrupt_mask         <= '1;
      interrupt_special_mask <= '0;
      end_of_interrupt       <= '1;
      priority_rotate        <= IDW'(N_IRQ - 1);
      r_auto_rotate          <= 1'b0;
      r_level_page           <= '0;
      r_byte_ptr             <= '0;
      r_sngl                 <= internal_data_bus[1];
      r_ic4                  <= internal_data_bus[0];
      if (!internal_data_bus[0]) begin
        mode_8086 <= 1'b0;
        r_aeoi    <= 1'b0;
      end
    end else begin
      end_of_interrupt <= w_ocw2_eoi | w_aeoi_eoi;
      if (w_ocw2_rot)      priority_rotate <= w_ocw2_rot_val;
      else if (w_aeoi_rot) priority_rotate <= w_ack_num[IDW-1:0];
      if (write_initial_command_word_2_4 && r_icw_state == WAIT_ICW4) begin
        mode_8086 <= internal_data_bus[0];
        r_aeoi    <= internal_data_bus[1];
      end
      if (w_ocw1) begin
        if (r_smm) interrupt_special_mask <= w_ocw1_new32[N_IRQ-1:0];
        else       interrupt_mask         <= w_ocw1_new32[N_IRQ-1:0];
        r_byte_ptr <= (r_byte_ptr == PW'(NBYTES - 1)) ? '0 : r_byte_ptr + PW'(1);
      end
      if (w_ocw2 || w_ocw3) r_byte_ptr <= '0;
      if (w_ocw2 && internal_data_bus[7:5] == OCW2_SET_AUTO_ROT) r_auto_rotate <= 1'b1;
      if (w_ocw2 && internal_data_bus[7:5] == OCW2_CLR_AUTO_ROT) r_auto_rotate <= 1'b0;
      if (w_ocw3) begin
        if (!internal_data_bus[7] && internal_data_bus[6]) begin
          r_smm <= internal_data_bus[5];
          if (!internal_data_bus[5]) interrupt_special_mask <= '0;
        end
        if (internal_data_bus[7] && IDW > 3) r_level_page <= internal_data_bus[LPW-1:0];
      end
    end
  end

  pic_ack_sequencer #(.N_IRQ(N_IRQ)) u_ack (
    .i_clock                 (clock),
    .i_reset                 (reset),
    .i_abort                 (write_initial_command_word_1),
    .i_inta_pulse            (inta_pulse),
    .i_mode_8086             (mode_8086),
    .i_interrupt             (interrupt),
    .o_freeze                (freeze),
    .o_latch_in_service      (latch_in_service),
    .o_acknowledge_interrupt (w_ack_int),
    .o_ack_done              (w_ack_done)
  );

  always_comb begin
    clear_interrupt_request = '0;
    if (write_initial_command_word_1) clear_interrupt_request = '1;
    else if (latch_in_service)        clear_interrupt_request = interrupt;
  end

  assign init_done = w_ready;

endmodule

// File: tb/tb_pic_control_core.sv
// tb/tb_pic_control_core.sv - directed self-checking bench for pic_control_core at N_IRQ=16
module tb_pic_control_core;

  localparam int N = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   bus;
  logic         icw1, icw24, ocw1, ocw2, ocw3, inta;
  logic [N-1:0] irq, hlis;
  logic [N-1:0] mask, smask, eoi, cir;
  logic [3:0]   rot;
  logic         frz, lis, m86, done;
  int           errors = 0;
  int           checks = 0;

  pic_control_core #(.N_IRQ(N)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .internal_data_bus              (bus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2_4 (icw24),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .inta_pulse                     (inta),
    .interrupt                      (irq),
    .highest_level_in_service       (hlis),
    .interrupt_mask                 (mask),
    .interrupt_special_mask         (smask),
    .end_of_interrupt               (eoi),
    .priority_rotate                (rot),
    .freeze                         (frz),
    .latch_in_service               (lis),
    .clear_interrupt_request        (cir),
    .mode_8086                      (m86),
    .init_done                      (done)
  );

  always #5 clock = ~clock;

  // kind: 1=ICW1 2=ICW2/3/4 3=OCW1 4=OCW2 5=OCW3
  task automatic wr(input int kind, input logic [7:0] d);
    @(negedge clock);
    bus   = d;
    icw1  = (kind == 1);
    icw24 = (kind == 2);
    ocw1  = (kind == 3);
    ocw2  = (kind == 4);
    ocw3  = (kind == 5);
    @(negedge clock);
    {icw1, icw24, ocw1, ocw2, ocw3} = '0;
  endtask

  task automatic pulse_inta();
    @(negedge clock);
    inta = 1'b1;
    @(negedge clock);
    inta = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL rst_mask got %h want ffff", mask); end
    checks++; if (smask !== 16'h0000) begin errors++; $display("FAIL rst_smask got %h want 0000", smask); end
    checks++; if (eoi !== 16'h0000) begin errors++; $display("FAIL rst_eoi got %h want 0000", eoi); end
    checks++; if (rot !== 4'd15) begin errors++; $display("FAIL rst_rot got %0d want 15", rot); end
    checks++; if ({frz, lis, m86, done} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {frz, lis, m86, done}); end
    checks++; if (cir !== 16'h0000) begin errors++; $display("FAIL rst_cir got %h want 0000", cir); end
    reset = 1'b0;
  endtask

  task automatic test_init();
    @(negedge clock);
    bus  = 8'h13;
    icw1 = 1'b1;
    #1;
    checks++; if (cir !== 16'hFFFF) begin errors++; $display("FAIL init_cir got %h want ffff", cir); end
    @(negedge clock);
    icw1 = 1'b0;
    checks++; if (eoi !== 16'hFFFF) begin errors++; $display("FAIL init_eoi got %h want ffff", eoi); end
    wr(2, 8'h20);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL init_icw2_done got %b want 0", done); end
    checks++; if (eoi !== 16'h0000) begin errors++; $display("FAIL init_eoi_pulse got %h want 0000", eoi); end
    wr(2, 8'h03);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", done); end
    checks++; if (m86 !== 1'b1) begin errors++; $display("FAIL init_m86 got %b want 1", m86); end
  endtask

  task automatic test_ack_8086();
    irq = 16'h0002;
    pulse_inta();
    checks++; if ({lis, frz} !== 2'b11) begin errors++; $display("FAIL a86_first got lis/frz %b want 11", {lis, frz}); end
    checks++; if (cir !== 16'h0002) begin errors++; $display("FAIL a86_cir got %h want 0002", cir); end
    @(negedge clock);
    inta = 1'b1;
    bus  = 8'h64;
    ocw2 = 1'b1;
    @(negedge clock);
    inta = 1'b0;
    ocw2 = 1'b0;
    checks++; if (eoi !== 16'h0012) begin errors++; $display("FAIL a86_eoi_or got %h want 0012", eoi); end
    checks++; if (frz !== 1'b0) begin errors++; $display("FAIL a86_frz got %b want 0", frz); end
    checks++; if (rot !== 4'd15) begin errors++; $display("FAIL a86_rot got %0d want 15", rot); end
    irq = '0;
  endtask

  task automatic test_ocw1();
    wr(3, 8'hA5);
    checks++; if (mask !== 16'hFFA5) begin errors++; $display("FAIL ocw1_b0 got %h want ffa5", mask); end
    wr(3, 8'h3C);
    checks++; if (mask !== 16'h3CA5) begin errors++; $display("FAIL ocw1_b1 got %h want 3ca5", mask); end
    wr(3, 8'hFF);
    checks++; if (mask !== 16'h3CFF) begin errors++; $display("FAIL ocw1_wrap got %h want 3cff", mask); end
    wr(5, 8'h60);
    wr(3, 8'h12);
    checks++; if (smask !== 16'h0012) begin errors++; $display("FAIL ocw1_smask got %h want 0012", smask); end
    checks++; if (mask !== 16'h3CFF) begin errors++; $display("FAIL ocw1_mask_kept got %h want 3cff", mask); end
    wr(5, 8'h40);
    checks++; if (smask !== 16'h0000) begin errors++; $display("FAIL ocw3_smm_clr got %h want 0000", smask); end
  endtask

  task automatic test_ocw2();
    wr(5, 8'h81);
    wr(4, 8'hE2);
    checks++; if (eoi !== 16'h0400) begin errors++; $display("FAIL ocw2_seoi got %h want 0400", eoi); end
    checks++; if (rot !== 4'd10) begin errors++; $display("FAIL ocw2_srot got %0d want 10", rot); end
    @(negedge clock);
    checks++; if (eoi !== 16'h0000) begin errors++; $display("FAIL ocw2_pulse got %h want 0000", eoi); end
    hlis = 16'h0020;
    wr(4, 8'h20);
    checks++; if (eoi !== 16'h0020 || rot !== 4'd10) begin errors++; $display("FAIL ocw2_nseoi got %h/%0d want 0020/10", eoi, rot); end
    hlis = 16'h0100;
    wr(4, 8'hA0);
    checks++; if (eoi !== 16'h0100 || rot !== 4'd8) begin errors++; $display("FAIL ocw2_rot_ns got %h/%0d want 0100/8", eoi, rot); end
    hlis = '0;
    wr(4, 8'hC5);
    checks++; if (eoi !== 16'h0000 || rot !== 4'd13) begin errors++; $display("FAIL ocw2_setprio got %h/%0d want 0000/13", eoi, rot); end
    wr(4, 8'hA0);
    checks++; if (eoi !== 16'h0000 || rot !== 4'd13) begin errors++; $display("FAIL ocw2_ns_empty got %h/%0d want 0000/13", eoi, rot); end
    wr(5, 8'h80);
    wr(4, 8'hC5);
    checks++; if (rot !== 4'd5) begin errors++; $display("FAIL ocw2_page0 got %0d want 5", rot); end
  endtask

  task automatic test_ack_aeoi();
    wr(1, 8'h13);
    wr(2, 8'h20);
    wr(2, 8'h02);
    checks++; if ({done, m86} !== 2'b10) begin errors++; $display("FAIL aeoi_init got done/m86 %b want 10", {done, m86}); end
    wr(4, 8'h80);
    wr(3, 8'h00);
    checks++; if (mask !== 16'hFF00) begin errors++; $display("FAIL aeoi_mask got %h want ff00", mask); end
    irq = 16'h0008;
    pulse_inta();
    checks++; if (lis !== 1'b1 || cir !== 16'h0008) begin errors++; $display("FAIL ack1 got lis/cir %b/%h want 1/0008", lis, cir); end
    pulse_inta();
    checks++; if (frz !== 1'b1 || eoi !== 16'h0000 || lis !== 1'b0) begin errors++; $display("FAIL ack2 got frz/eoi/lis %b/%h/%b want 1/0000/0", frz, eoi, lis); end
    pulse_inta();
    checks++; if (eoi !== 16'h0008 || rot !== 4'd3 || frz !== 1'b0) begin errors++; $display("FAIL ack3 got eoi/rot/frz %h/%0d/%b want 0008/3/0", eoi, rot, frz); end
    irq = '0;
    repeat (3) pulse_inta();
    checks++; if (eoi !== 16'h0000 || rot !== 4'd3 || frz !== 1'b0) begin errors++; $display("FAIL spurious got eoi/rot/frz %h/%0d/%b want 0000/3/0", eoi, rot, frz); end
  endtask

  task automatic test_icw1_abort();
    irq = 16'h0004;
    pulse_inta();
    checks++; if (frz !== 1'b1) begin errors++; $display("FAIL abort_pre_frz got %b want 1", frz); end
    @(negedge clock);
    bus  = 8'h13;
    icw1 = 1'b1;
    #1;
    checks++; if (cir !== 16'hFFFF) begin errors++; $display("FAIL abort_cir got %h want ffff", cir); end
    @(negedge clock);
    icw1 = 1'b0;
    checks++; if (frz !== 1'b0 || lis !== 1'b0) begin errors++; $display("FAIL abort_frz got frz/lis %b/%b want 0/0", frz, lis); end
    checks++; if (mask !== 16'hFFFF || eoi !== 16'hFFFF) begin errors++; $display("FAIL abort_mask_eoi got %h/%h want ffff/ffff", mask, eoi); end
    checks++; if (rot !== 4'd15 || done !== 1'b0) begin errors++; $display("FAIL abort_rot got rot/done %0d/%b want 15/0", rot, done); end
    irq = '0;
  endtask

  task automatic test_async_reset();
    wr(1, 8'h10);
    wr(2, 8'h20);
    irq = 16'h0004;
    @(negedge clock);
    inta = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (lis !== 1'b0 || frz !== 1'b0) begin errors++; $display("FAIL areset_ack got lis/frz %b/%b want 0/0", lis, frz); end
    checks++; if (cir !== 16'h0000 || eoi !== 16'h0000) begin errors++; $display("FAIL areset_cir got cir/eoi %h/%h want 0000/0000", cir, eoi); end
    checks++; if (mask !== 16'hFFFF || rot !== 4'd15 || done !== 1'b0) begin errors++; $display("FAIL areset_state got %h/%0d/%b want ffff/15/0", mask, rot, done); end
    @(negedge clock);
    inta = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    irq = '0;
    wr(2, 8'h03);
    wr(2, 8'h03);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_icw2_ignored got %b want 0", done); end
    wr(3, 8'h00);
    checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL areset_ocw1_ignored got %h want ffff", mask); end
  endtask

  initial begin
    bus   = '0;
    {icw1, icw24, ocw1, ocw2, ocw3, inta} = '0;
    irq   = '0;
    hlis  = '0;
    reset = 1'b1;
    test_reset();
    test_init();
    test_ack_8086();
    test_ocw1();
    test_ocw2();
    test_ack_aeoi();
    test_icw1_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
